byte_striping: RTL and testbench



---
 rtl/byte_striping_pkg.sv | 14 +
 rtl/byte_striping_lane_pointer.sv | 25 ++
 rtl/byte_striping.sv | 100 ++++++++++
 tb/tb_byte_striping.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striping (transmit) and byte joining (receive) paths.
package byte_striping_pkg;

  localparam int unsigned NUM_LANES   = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned LANE_IDX_W  = 2;

  typedef logic [BYTE_W-1:0]     byte_t;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // K28.5 comma symbol, used as filler for lanes of a flushed partial group
  localparam byte_t PAD_BYTE = 8'hBC;

endpackage

// File: rtl/byte_striping_lane_pointer.sv
// Mod-NUM_LANES lane pointer with increment enable and synchronous clear.
module lane_pointer
  import byte_striping_pkg::*;
#(
  parameter int unsigned LANES = NUM_LANES
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      clr,
  output lane_idx_t ptr,
  output logic      last
);

  assign last = (ptr == lane_idx_t'(LANES - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= last ? '0 : ptr + lane_idx_t'(1);
    end
  end

endmodule

// File: rtl/byte_striping.sv
// Round-robin byte striper: four bytes per group onto four lanes with a one-cycle strobe.
// Optional flush/padding of partial groups is enabled by defining BYTE_STRIPING_PAD_EN.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int unsigned NUM_LANES = byte_striping_pkg::NUM_LANES,
  parameter byte_t       PAD_BYTE  = byte_striping_pkg::PAD_BYTE
) (
  input  logic      clk1Mhz,
  input  logic      reset,
  input  byte_t     data_in,
  input  logic      valid_in,
  input  logic      flush,
  output byte_t     Lane_0,
  output byte_t     Lane_1,
  output byte_t     Lane_2,
  output byte_t     Lane_3,
  output logic      lanes_valid,
  output lane_idx_t crt_3
);

  localparam int unsigned STAGES = NUM_LANES - 1;

  byte_t     stage_q  [STAGES];
  byte_t     stage_d  [STAGES];
  byte_t     lane_q   [NUM_LANES];
  byte_t     lane_d   [NUM_LANES];
  logic      strobe_d;
  logic      last;
  logic      flush_clr_c;
  lane_idx_t ptr;

  lane_pointer #(
    .LANES (NUM_LANES)
  ) u_lane_pointer (
    .clk   (clk1Mhz),
    .reset (reset),
    .inc   (valid_in),
    .clr   (flush_clr_c),
    .ptr   (ptr),
    .last  (last)
  );

  // Next staging/lane values; a completing byte always wins over a flush
  always_comb begin
    stage_d     = stage_q;
    lane_d      = lane_q;
    strobe_d    = 1'b0;
    flush_clr_c = 1'b0;
    if (valid_in && !last) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (ptr == lane_idx_t'(i)) stage_d[i] = data_in;
      end
    end
    if (valid_in && last) begin
      for (int i = 0; i < int'(STAGES); i++) lane_d[i] = stage_q[i];
      lane_d[NUM_LANES-1] = data_in;
      strobe_d            = 1'b1;
    end
`ifdef BYTE_STRIPING_PAD_EN
    else if (flush && (valid_in || ptr != '0)) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (lane_idx_t'(i) < ptr)
          lane_d[i] = (i < int'(STAGES)) ? stage_q[i % int'(STAGES)] : PAD_BYTE;
        else if (valid_in && lane_idx_t'(i) == ptr)
          lane_d[i] = data_in;
        else
          lane_d[i] = PAD_BYTE;
      end
      strobe_d    = 1'b1;
      flush_clr_c = 1'b1;
    end
`endif
  end

`ifndef BYTE_STRIPING_PAD_EN
  // Port and pad byte kept for a stable interface; consumed here only
  logic unused_flush;
  assign unused_flush = ^{flush, PAD_BYTE};
`endif

  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) lane_q[i] <= '0;
      lanes_valid <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      lane_q      <= lane_d;
      lanes_valid <= strobe_d;
    end
  end

  assign Lane_0 = lane_q[0];
  assign Lane_1 = lane_q[1];
  assign Lane_2 = lane_q[2];
  assign Lane_3 = lane_q[3];
  assign crt_3  = ptr;

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping; flush cases follow BYTE_STRIPING_PAD_EN.
module tb_byte_striping;
  import byte_striping_pkg::*;

  logic      clk1Mhz = 1'b0;
  logic      reset   = 1'b1;
  byte_t     data_in = '0;
  logic      valid_in = 1'b0;
  logic      flush    = 1'b0;
  byte_t     Lane_0, Lane_1, Lane_2, Lane_3;
  logic      lanes_valid;
  lane_idx_t crt_3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  byte_striping dut (
    .clk1Mhz     (clk1Mhz),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .flush       (flush),
    .Lane_0      (Lane_0),
    .Lane_1      (Lane_1),
    .Lane_2      (Lane_2),
    .Lane_3      (Lane_3),
    .lanes_valid (lanes_valid),
    .crt_3       (crt_3)
  );

  always #5 clk1Mhz = ~clk1Mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input byte_t a, input byte_t b,
                           input byte_t c, input byte_t d);
    chk({tag, ".lane0"}, 32'(Lane_0), 32'(a));
    chk({tag, ".lane1"}, 32'(Lane_1), 32'(b));
    chk({tag, ".lane2"}, 32'(Lane_2), 32'(c));
    chk({tag, ".lane3"}, 32'(Lane_3), 32'(d));
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge
  task automatic step(input logic v, input byte_t d, input logic f, input logic r);
    valid_in = v;
    data_in  = d;
    flush    = f;
    reset    = r;
    @(posedge clk1Mhz);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    int strobes;
    // Reset
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("rst.crt", 32'(crt_3), 32'd0);
    chk("rst.valid", 32'(lanes_valid), 32'd0);
    chk_lanes("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    // Continuous stream 00..07
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stream.crt%0d", i), 32'(crt_3), 32'(i % 4));
      step(1'b1, byte_t'(i), 1'b0, 1'b0);
      chk($sformatf("stream.valid%0d", i), 32'(lanes_valid), 32'((i % 4) == 3));
      if (i == 3) chk_lanes("grp0", 8'h00, 8'h01, 8'h02, 8'h03);
      if (i == 7) chk_lanes("grp1", 8'h04, 8'h05, 8'h06, 8'h07);
    end
    chk("stream.crt_end", 32'(crt_3), 32'd0);

    // Sparse stream with idle cycles
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, byte_t'(8'hA0 + i), 1'b0, 1'b0);
      if (lanes_valid) strobes++;
      if (i < 3) begin
        step(1'b0, 8'hFF, 1'b0, 1'b0);
        if (lanes_valid) strobes++;
      end
    end
    chk("sparse.strobes", 32'(strobes), 32'd1);
    chk("sparse.valid_last", 32'(lanes_valid), 32'd1);
    chk_lanes("sparse", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sparse.valid_off", 32'(lanes_valid), 32'd0);
    chk_lanes("sparse.hold", 8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // Reset discards a partial group; reset wins over valid_in
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("rstmid.crt_pre", 32'(crt_3), 32'd2);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    chk("rstmid.crt", 32'(crt_3), 32'd0);
    chk("rstmid.valid", 32'(lanes_valid), 32'd0);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, byte_t'(8'h33 + i), 1'b0, 1'b0);
      if (lanes_valid) strobes++;
    end
    chk("rstmid.strobes", 32'(strobes), 32'd1);
    chk("rstmid.valid_last", 32'(lanes_valid), 32'd1);
    chk_lanes("rstmid", 8'h33, 8'h34, 8'h35, 8'h36);

`ifdef BYTE_STRIPING_PAD_EN
    // Flush alone after one byte
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pad1.valid", 32'(lanes_valid), 32'd1);
    chk("pad1.crt", 32'(crt_3), 32'd0);
    chk_lanes("pad1", 8'h55, 8'hBC, 8'hBC, 8'hBC);
    // Flush with empty group
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pad_empty.valid", 32'(lanes_valid), 32'd0);
    chk_lanes("pad_empty.hold", 8'h55, 8'hBC, 8'hBC, 8'hBC);
    // Flush on the 3rd byte
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h30, 1'b1, 1'b0);
    chk("pad3.valid", 32'(lanes_valid), 32'd1);
    chk("pad3.crt", 32'(crt_3), 32'd0);
    chk_lanes("pad3", 8'h10, 8'h20, 8'h30, 8'hBC);
    // Flush on the 4th byte: normal group only
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h50, 1'b0, 1'b0);
    step(1'b1, 8'h60, 1'b0, 1'b0);
    step(1'b1, 8'h70, 1'b1, 1'b0);
    chk("pad4.valid", 32'(lanes_valid), 32'd1);
    chk("pad4.crt", 32'(crt_3), 32'd0);
    chk_lanes("pad4", 8'h40, 8'h50, 8'h60, 8'h70);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pad4.no_extra", 32'(lanes_valid), 32'd0);
`else
    // Flush ignored: partial group persists
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("noflush.valid", 32'(lanes_valid), 32'd0);
    chk("noflush.crt", 32'(crt_3), 32'd1);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, byte_t'(8'h78 + i), 1'b0, 1'b0);
      if (lanes_valid) strobes++;
    end
    chk("noflush.strobes", 32'(strobes), 32'd1);
    chk("noflush.valid_last", 32'(lanes_valid), 32'd1);
    chk_lanes("noflush", 8'h77, 8'h78, 8'h79, 8'h7A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
